// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
//   Shared definitions for the UART transmit FIFO slice: the default byte
//   width (must match the uart_tx din width), the default FIFO geometry and
//   the launcher state encoding used by uart_tx_fifo.
//   No ports (package).
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DONE = 2'd2
    } launch_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_sync_fifo
//   Generic synchronous circular FIFO: register-array storage, wrapping
//   read/write pointers, and a registered occupancy count with full/empty
//   flags. The head entry is presented combinationally on rd_data.
//   The caller must only push when not full and only pop when not empty.
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous, active-low reset
//   push     in   write wr_data at the tail this edge
//   pop      in   drop the head entry this edge
//   clear    in   synchronous clear of pointers and count (wins over push/pop)
//   wr_data  in   DATA_W byte to store
//   rd_data  out  DATA_W head entry (mem[rd_ptr])
//   full     out  count == DEPTH (registered)
//   empty    out  count == 0 (registered)
//   count    out  ADDR_W+1 entries stored (registered)
// ---------------------------------------------------------------------------
module uart_tx_fifo_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;

    assign rd_data = mem[rd_ptr];

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (!push && pop) begin
            count_next = count - CNT_ONE;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The flags are
    // derived from count_next so they line up with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit-side buffer and launcher for the uart_tx serialiser. Bytes from
//   the host are queued in a circular FIFO and handed to uart_tx one at a
//   time through its start/din/busy handshake, so producers can burst up to
//   DEPTH bytes without waiting on the baud rate.
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous, active-low reset
//   wr_en     in   push request
//   wr_data   in   DATA_W byte to push
//   flush     in   synchronous clear of FIFO contents
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  ADDR_W+1 entries stored
//   overflow  out  one-cycle pulse: push rejected because FIFO was full
//   tx_start  out  one-cycle launch pulse to uart_tx.start
//   tx_data   out  DATA_W byte to uart_tx.din, held until the next launch
//   tx_busy   in   uart_tx.busy
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy
);

    launch_state_t     state;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;

    // Flush discards a concurrent write outright, so it neither stores nor
    // counts as an overflow. Rejection uses the registered full flag even if
    // a pop happens on the same edge.
    assign push = wr_en && !full && !flush;
    assign pop  = (state == S_IDLE) && !empty && !tx_busy && !flush;

    uart_tx_fifo_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .clear   (flush),
        .wr_data (wr_data),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full && !flush;
        end
    end

    // Launcher: pulse start for one cycle, wait for uart_tx to raise busy,
    // then wait for busy to fall before the next byte may go. Flush only
    // blocks a new launch; a frame already handed over runs to completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        tx_start <= 1'b1;
                        tx_data  <= head_data;
                        state    <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    tx_start <= 1'b0;
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    tx_start <= 1'b0;
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Bench for uart_tx_fifo with a simple uart_tx stand-in (busy for FRAME
//   cycles after each start, optionally held busy). A queue-based model of
//   the FIFO and the launch rules is stepped once per cycle and compared
//   against all outputs; directed tests add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int FRAME = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // uart_tx stand-in
    int   uart_cnt = 0;
    logic hold_busy;

    // Inputs as seen at the most recent rising edge
    logic       s_wr    = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_flush = 1'b0;
    logic       s_busy  = 1'b0;
    logic       s_rst   = 1'b0;

    // Behavioural model state
    logic [7:0] q[$];
    logic [7:0] exp_data   = 8'h00;
    logic       frame_open = 1'b0;
    logic       saw_busy   = 1'b0;
    logic       m_full;
    logic       m_empty;
    logic       exp_start;
    logic       exp_ovf;
    logic [7:0] popped;

    // What the DUT actually launched
    logic [7:0] out_bytes[$];
    int         out_cyc[$];

    uart_tx_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = (uart_cnt != 0) || hold_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_cnt <= 0;
        end else if (tx_start) begin
            uart_cnt <= FRAME;
        end else if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
        end
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_wr    <= wr_en;
        s_data  <= wr_data;
        s_flush <= flush;
        s_busy  <= tx_busy;
        s_rst   <= rst_n;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one cycle of inputs; returns 2ns after the edge that sampled them.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic f);
        wr_en   = w;
        wr_data = d;
        flush   = f;
        @(posedge clk);
        #2;
    endtask

    task automatic waitBytes(input int n, input int budget, input string name);
        int k = 0;
        while (out_bytes.size() < n && k < budget) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            k++;
        end
        checkOutput(name, out_bytes.size(), n);
    endtask

    // Model step for the edge just passed, then compare every output.
    always @(negedge clk) begin
        if (!rst_n || !s_rst) begin
            q.delete();
            exp_data   = 8'h00;
            frame_open = 1'b0;
            saw_busy   = 1'b0;
            checkOutput("rst_count", int'(count), 0);
            checkOutput("rst_empty", int'(empty), 1);
            checkOutput("rst_full", int'(full), 0);
            checkOutput("rst_tx_start", int'(tx_start), 0);
            checkOutput("rst_overflow", int'(overflow), 0);
            checkOutput("rst_tx_data", int'(tx_data), 0);
        end else begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            exp_ovf = s_wr && m_full && !s_flush;
            // A byte may go only when no frame is outstanding; a frame ends
            // at the first edge that sees busy low after it was seen high.
            exp_start = !frame_open && !m_empty && !s_busy && !s_flush;
            if (frame_open) begin
                if (s_busy) begin
                    saw_busy = 1'b1;
                end else if (saw_busy) begin
                    frame_open = 1'b0;
                    saw_busy   = 1'b0;
                end
            end
            if (exp_start) begin
                popped     = q.pop_front();
                exp_data   = popped;
                frame_open = 1'b1;
                saw_busy   = 1'b0;
            end
            if (s_flush) begin
                q.delete();
            end else if (s_wr && !m_full) begin
                q.push_back(s_data);
            end
            checkOutput("tx_start", int'(tx_start), int'(exp_start));
            checkOutput("tx_data", int'(tx_data), int'(exp_data));
            checkOutput("overflow", int'(overflow), int'(exp_ovf));
            checkOutput("count", int'(count), q.size());
            checkOutput("full", int'(full), int'(q.size() == DEPTH));
            checkOutput("empty", int'(empty), int'(q.size() == 0));
            if (tx_start) begin
                out_bytes.push_back(tx_data);
                out_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n0;
        int c0;
        int i;
        int iter;

        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        flush     = 1'b0;
        hold_busy = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("init_count", int'(count), 0);
        checkOutput("init_empty", int'(empty), 1);
        checkOutput("init_tx_data", int'(tx_data), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] test 1: single byte latency");
        n0 = out_bytes.size();
        c0 = cyc;
        applyStimulus(1'b1, 8'hA5, 1'b0);
        waitBytes(n0 + 1, 20, "t1_launch");
        if (out_bytes.size() > n0) begin
            checkOutput("t1_latency", out_cyc[n0] - c0, 2);
            checkOutput("t1_byte", int'(out_bytes[n0]), 8'hA5);
        end
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1_count", int'(count), 0);
        checkOutput("t1_empty", int'(empty), 1);

        $display("[TB] test 2: fill, overflow, drain");
        hold_busy = 1'b1;
        n0 = out_bytes.size();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0);
        end
        checkOutput("t2_full", int'(full), 1);
        checkOutput("t2_count", int'(count), 16);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("t2_overflow_pulse", int'(overflow), 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t2_overflow_clear", int'(overflow), 0);
        checkOutput("t2_count_kept", int'(count), 16);
        hold_busy = 1'b0;
        waitBytes(n0 + 16, 300, "t2_drain");
        for (int k = 0; k < 16 && n0 + k < out_bytes.size(); k++) begin
            checkOutput($sformatf("t2_order_%0d", k), int'(out_bytes[n0 + k]), k);
        end
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] test 3: streaming across pointer wrap");
        n0   = out_bytes.size();
        i    = 0;
        iter = 0;
        while (i < 40 && iter < 3000) begin
            if (!full && $urandom_range(0, 2) != 0) begin
                applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
                i++;
            end else begin
                applyStimulus(1'b0, 8'h00, 1'b0);
            end
            iter++;
        end
        checkOutput("t3_pushed", i, 40);
        waitBytes(n0 + 40, 600, "t3_drain");
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t3_pulses", out_bytes.size() - n0, 40);
        for (int k = 0; k < 40 && n0 + k < out_bytes.size(); k++) begin
            checkOutput($sformatf("t3_order_%0d", k), int'(out_bytes[n0 + k]), 8'h40 + k);
        end

        $display("[TB] test 4: flush during a frame");
        n0 = out_bytes.size();
        applyStimulus(1'b1, 8'h50, 1'b0);
        waitBytes(n0 + 1, 20, "t4_first");
        hold_busy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 8'(8'h50 + k), 1'b0);
        end
        checkOutput("t4_queued", int'(count), 5);
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkOutput("t4_flush_count", int'(count), 0);
        checkOutput("t4_flush_empty", int'(empty), 1);
        checkOutput("t4_flush_no_ovf", int'(overflow), 0);
        hold_busy = 1'b0;
        repeat (30) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t4_no_more_starts", out_bytes.size() - n0, 1);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        waitBytes(n0 + 2, 20, "t4_relaunch");
        if (out_bytes.size() > n0 + 1) begin
            checkOutput("t4_relaunch_byte", int'(out_bytes[n0 + 1]), 8'h5A);
        end
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] test 5: reset mid-burst");
        hold_busy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 8'(8'h70 + k), 1'b0);
        end
        checkOutput("t5_count_before", int'(count), 7);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_count", int'(count), 0);
        checkOutput("t5_rst_empty", int'(empty), 1);
        checkOutput("t5_rst_start", int'(tx_start), 0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        hold_busy = 1'b0;
        n0 = out_bytes.size();
        c0 = cyc;
        applyStimulus(1'b1, 8'h3C, 1'b0);
        waitBytes(n0 + 1, 20, "t5_launch");
        if (out_bytes.size() > n0) begin
            checkOutput("t5_byte", int'(out_bytes[n0]), 8'h3C);
            checkOutput("t5_latency", out_cyc[n0] - c0, 2);
        end
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
